// File: rtl/serial_parity_checker.sv
// Serial even/odd parity checker: frames DATA_BITS data bits plus one trailing
// parity bit, reports the expected parity and mismatch, and keeps frame/error counters.
module serial_parity_checker #(
  parameter int unsigned DATA_BITS = 8,
  parameter bit          ODD       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       busy,
  output logic       done,
  output logic       exp_parity,
  output logic       parity_err,
  output logic [7:0] frame_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BIT = 8'(DATA_BITS - 1);

  // Input handshake: in_valid qualifies in_bit for one cycle; there is no
  // ready, so a bit presented with in_valid=1 in DATA/PARITY is always taken,
  // and bits presented in IDLE or DONE are dropped.
  state_t     r_state;
  state_t     w_next_state;
  logic       r_acc;
  logic [7:0] r_bit_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_exp_parity;
  logic       r_parity_err;
  logic [7:0] r_frame_count;
  logic [7:0] r_err_count;
  logic       w_exp;
  logic       w_err;

  assign w_exp = r_acc ^ ODD;
  assign w_err = in_bit ^ w_exp;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_DATA;
      S_DATA:   if (in_valid && (r_bit_cnt == LAST_BIT)) w_next_state = S_PARITY;
      S_PARITY: if (in_valid) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_acc         <= 1'b0;
      r_bit_cnt     <= 8'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_exp_parity  <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_count <= 8'd0;
      r_err_count   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      // Status flags are registered from the next state so they line up with it.
      r_busy  <= (w_next_state == S_DATA) || (w_next_state == S_PARITY);
      r_done  <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc     <= 1'b0;
            r_bit_cnt <= 8'd0;
          end
        end
        S_DATA: begin
          if (in_valid) begin
            r_acc     <= r_acc ^ in_bit;
            r_bit_cnt <= r_bit_cnt + 8'd1;
          end
        end
        S_PARITY: begin
          if (in_valid) begin
            r_exp_parity  <= w_exp;
            r_parity_err  <= w_err;
            r_frame_count <= r_frame_count + 8'd1;
            if (w_err && (r_err_count != 8'hFF)) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign exp_parity  = r_exp_parity;
  assign parity_err  = r_parity_err;
  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an even-parity and an odd-parity
// instance share one stimulus stream; results are checked against hand values.
module tb_serial_parity_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_bit;
  logic       busy0, done0, exp0, err0;
  logic [7:0] fc0, ec0;
  logic       busy1, done1, exp1, err1;
  logic [7:0] fc1, ec1;

  int         n_checks;
  int         n_errors;
  int         done_pulses;
  logic [1:0] exp_q[$];
  logic [1:0] mon_pair;

  serial_parity_checker #(.DATA_BITS(8), .ODD(1'b0)) u_dut_even (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy0), .done(done0), .exp_parity(exp0), .parity_err(err0),
    .frame_count(fc0), .err_count(ec0)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD(1'b1)) u_dut_odd (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy1), .done(done1), .exp_parity(exp1), .parity_err(err1),
    .frame_count(fc1), .err_count(ec1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every done pulse of the even instance must match the queued result.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", {15'd0, done0}, 16'd0);
      end else begin
        mon_pair = exp_q.pop_front();
        check_eq("done_result", {14'd0, exp0, err0}, {14'd0, mon_pair});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_outputs0(input string tag, input logic ex, input logic er,
                                input logic [7:0] fc, input logic [7:0] ec);
    check_eq({tag, "_exp"}, {15'd0, exp0}, {15'd0, ex});
    check_eq({tag, "_err"}, {15'd0, err0}, {15'd0, er});
    check_eq({tag, "_fc"}, {8'd0, fc0}, {8'd0, fc});
    check_eq({tag, "_ec"}, {8'd0, ec0}, {8'd0, ec});
  endtask

  // Sends start, 8 data bits (LSB first), then the parity bit. max_gap>0 inserts
  // 1..max_gap idle cycles before each bit and pulses start mid-frame.
  task automatic send_frame(input logic [7:0] data, input logic par, input int max_gap,
                            input logic [1:0] exp_pair);
    int cyc;
    int gaps;
    cyc = 0;
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick(); cyc++;
    start = 1'b0; in_valid = 1'b0;
    check_eq("busy_after_start", {15'd0, busy0}, 16'd1);
    for (int i = 0; i < 8; i++) begin
      gaps = (max_gap > 0) ? $urandom_range(max_gap, 1) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        start = (i == 3 && g == 0) ? 1'b1 : 1'b0;
        tick(); cyc++;
        start = 1'b0;
      end
      in_valid = 1'b1; in_bit = data[i];
      tick(); cyc++;
    end
    in_valid = 1'b1; in_bit = par;
    exp_q.push_back(exp_pair);
    tick(); cyc++;
    in_valid = 1'b0; in_bit = 1'b0;
    check_eq("done_even", {15'd0, done0}, 16'd1);
    check_eq("done_odd", {15'd0, done1}, 16'd1);
    if (max_gap == 0) check_eq("start_to_done", cyc[15:0], 16'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("done_one_cycle", {15'd0, done0}, 16'd0);
    check_eq("busy_after_done", {15'd0, busy0}, 16'd0);
  endtask

  initial begin
    int d_before;
    n_checks = 0; n_errors = 0; done_pulses = 0;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_busy", {15'd0, busy0}, 16'd0);
    check_eq("rst_done", {15'd0, done0}, 16'd0);
    check_outputs0("rst", 1'b0, 1'b0, 8'd0, 8'd0);

    // Even frame 0xA5, good parity
    send_frame(8'hA5, 1'b0, 0, 2'b00);
    check_outputs0("even_good", 1'b0, 1'b0, 8'd1, 8'd0);

    // Even frame 0xA5, bad parity; flags held while idle
    do_reset();
    send_frame(8'hA5, 1'b1, 0, 2'b01);
    check_outputs0("even_bad", 1'b0, 1'b1, 8'd1, 8'd1);
    repeat (3) tick();
    check_eq("err_held", {15'd0, err0}, 16'd1);

    // Stalls and ignored starts, 0x07 with parity 1
    d_before = done_pulses;
    send_frame(8'h07, 1'b1, 3, 2'b10);
    repeat (2) tick();
    check_eq("one_done_pulse", 16'(done_pulses - d_before), 16'd1);
    check_outputs0("stall", 1'b1, 1'b0, 8'd2, 8'd1);

    // Odd-parity instance
    send_frame(8'h00, 1'b1, 0, 2'b01);
    check_eq("odd_zero_exp", {15'd0, exp1}, 16'd1);
    check_eq("odd_zero_err", {15'd0, err1}, 16'd0);
    send_frame(8'hFF, 1'b0, 0, 2'b00);
    check_eq("odd_ff_exp", {15'd0, exp1}, 16'd1);
    check_eq("odd_ff_err", {15'd0, err1}, 16'd1);
    check_outputs0("after_odd", 1'b0, 1'b0, 8'd4, 8'd2);

    // Reset mid-frame after 4 data bits
    d_before = done_pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      tick();
    end
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("midrst_busy", {15'd0, busy0}, 16'd0);
    check_eq("midrst_done", {15'd0, done0}, 16'd0);
    check_outputs0("midrst", 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (12) tick();
    check_eq("midrst_no_done", 16'(done_pulses - d_before), 16'd0);
    send_frame(8'hA5, 1'b0, 0, 2'b00);
    check_outputs0("post_rst", 1'b0, 1'b0, 8'd1, 8'd0);

    // Counter limits: 256 bad-parity frames
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      send_frame(8'h00, 1'b1, 0, 2'b01);
      if (n == 254) check_eq("ec_254", {8'd0, ec0}, 16'd254);
      if (n == 255) begin
        check_eq("fc_255", {8'd0, fc0}, 16'd255);
        check_eq("ec_255", {8'd0, ec0}, 16'd255);
      end
    end
    check_eq("fc_wrap", {8'd0, fc0}, 16'd0);
    check_eq("ec_sat", {8'd0, ec0}, 16'd255);

    repeat (2) tick();
    check_eq("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
